core_scheduler: RTL and testbench

CORE_SCHEDULER -- requirements
Module: core_scheduler

---
 rtl/core_scheduler.sv | 134 +++++++++++++
 tb/tb_core_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/core_scheduler.sv
// Per-block instruction sequencer: FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE loop.
// Define SCHED_CYCLE_COUNT_EN to build the saturating busy-cycle counter.
module core_scheduler #(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned PC_BITS           = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [7:0]                           block_id,
    input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
    output logic                                 fetch_req,
    input  logic                                 fetch_valid,
    input  logic                                 decoded_ret,
    input  logic [PC_BITS-1:0]                   next_pc,
    input  logic [THREADS_PER_BLOCK-1:0]         lsu_pending,
    output logic [THREADS_PER_BLOCK-1:0]         thread_enable,
    output logic [7:0]                           cur_block_id,
    output logic [PC_BITS-1:0]                   current_pc,
    output logic [2:0]                           core_state,
    output logic                                 done,
    output logic [15:0]                          cycle_count
);

    localparam int unsigned TCW = $clog2(THREADS_PER_BLOCK) + 1;
    localparam logic [TCW-1:0] TC_MAX = TCW'(THREADS_PER_BLOCK);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        REQUEST = 3'd3,
        WAIT    = 3'd4,
        EXECUTE = 3'd5,
        UPDATE  = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t                         state_q;
    logic [PC_BITS-1:0]             pc_q;
    logic [7:0]                     blk_q;
    logic [THREADS_PER_BLOCK-1:0]   en_q;
    logic                           done_q;

    logic [TCW-1:0]                 tc_clamped_d;
    logic [THREADS_PER_BLOCK-1:0]   en_mask_d;

    always_comb begin
        tc_clamped_d = (thread_count > TC_MAX) ? TC_MAX : thread_count;
        en_mask_d    = '0;
        for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
            en_mask_d[i] = (TCW'(i) < tc_clamped_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            blk_q   <= '0;
            en_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        blk_q <= block_id;
                        en_q  <= en_mask_d;
                        pc_q  <= '0;
                        // An empty block completes without ever touching the fetcher.
                        if (tc_clamped_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (fetch_valid) state_q <= DECODE;
                end
                DECODE:  state_q <= REQUEST;
                REQUEST: state_q <= WAIT;
                WAIT: begin
                    if ((lsu_pending & en_q) == '0) state_q <= EXECUTE;
                end
                EXECUTE: state_q <= UPDATE;
                UPDATE: begin
                    if (decoded_ret) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        pc_q    <= next_pc;
                        state_q <= FETCH;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        en_q    <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fetch_req     = (state_q == FETCH);
    assign thread_enable = en_q;
    assign cur_block_id  = blk_q;
    assign current_pc    = pc_q;
    assign core_state    = state_q;
    assign done          = done_q;

`ifdef SCHED_CYCLE_COUNT_EN
    logic [15:0] cyc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
        end else if (state_q == IDLE) begin
            if (start) cyc_q <= '0;
        end else if (cyc_q != '1) begin
            cyc_q <= cyc_q + 16'd1;
        end
    end

    assign cycle_count = cyc_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_core_scheduler.sv
// Directed self-checking bench for core_scheduler (default parameters).
module tb_core_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  block_id;
    logic [2:0]  thread_count;
    logic        fetch_req;
    logic        fetch_valid;
    logic        decoded_ret;
    logic [7:0]  next_pc;
    logic [3:0]  lsu_pending;
    logic [3:0]  thread_enable;
    logic [7:0]  cur_block_id;
    logic [7:0]  current_pc;
    logic [2:0]  core_state;
    logic        done;
    logic [15:0] cycle_count;

    int checks = 0;
    int errors = 0;

`ifdef SCHED_CYCLE_COUNT_EN
    localparam logic [15:0] EXP_CYC_SINGLE = 16'd7;
`else
    localparam logic [15:0] EXP_CYC_SINGLE = 16'd0;
`endif

    core_scheduler #(.THREADS_PER_BLOCK(4), .PC_BITS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .block_id     (block_id),
        .thread_count (thread_count),
        .fetch_req    (fetch_req),
        .fetch_valid  (fetch_valid),
        .decoded_ret  (decoded_ret),
        .next_pc      (next_pc),
        .lsu_pending  (lsu_pending),
        .thread_enable(thread_enable),
        .cur_block_id (cur_block_id),
        .current_pc   (current_pc),
        .core_state   (core_state),
        .done         (done),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; block_id = 8'h00; thread_count = 3'd0;
        fetch_valid = 1'b0; decoded_ret = 1'b0; next_pc = 8'h00; lsu_pending = 4'h0;
        tick(); tick();
        checks++; if (core_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", core_state); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL reset_fetch_req got %0b exp 0", fetch_req); end
        checks++; if (thread_enable !== 4'h0) begin errors++; $display("FAIL reset_enable got %b exp 0000", thread_enable); end
        checks++; if (current_pc !== 8'h00 || cur_block_id !== 8'h00) begin errors++; $display("FAIL reset_pc_blk got %0h/%0h exp 0/0", current_pc, cur_block_id); end
        checks++; if (cycle_count !== 16'h0) begin errors++; $display("FAIL reset_cycle_count got %0d exp 0", cycle_count); end
        reset = 1'b0;
        tick();
        checks++; if (core_state !== 3'd0) begin errors++; $display("FAIL idle_no_start got %0d exp 0", core_state); end
    endtask

    task automatic test_single();
        int e;
        thread_count = 3'd4; block_id = 8'hA5; decoded_ret = 1'b1; next_pc = 8'h55;
        fetch_valid = 1'b0; lsu_pending = 4'h0; start = 1'b1;
        tick();
        checks++; if (core_state !== 3'd1 || fetch_req !== 1'b1) begin errors++; $display("FAIL single_launch got st=%0d fr=%0b exp st=1 fr=1", core_state, fetch_req); end
        checks++; if (thread_enable !== 4'b1111 || cur_block_id !== 8'hA5) begin errors++; $display("FAIL single_latch got en=%b blk=%0h exp 1111/a5", thread_enable, cur_block_id); end
        tick();
        e = 1;
        checks++; if (core_state !== 3'd1 || fetch_req !== 1'b1) begin errors++; $display("FAIL single_fetch_hold got st=%0d fr=%0b exp 1/1", core_state, fetch_req); end
        fetch_valid = 1'b1;
        while (done !== 1'b1 && e < 30) begin
            tick(); e++;
            fetch_valid = 1'b0;
        end
        checks++; if (e !== 7) begin errors++; $display("FAIL single_latency got %0d exp 7", e); end
        checks++; if (core_state !== 3'd7 || current_pc !== 8'h00) begin errors++; $display("FAIL single_done got st=%0d pc=%0h exp 7/0", core_state, current_pc); end
        checks++; if (cycle_count !== EXP_CYC_SINGLE) begin errors++; $display("FAIL single_cycle_count got %0d exp %0d", cycle_count, EXP_CYC_SINGLE); end
        tick();
        checks++; if (core_state !== 3'd7 || done !== 1'b1) begin errors++; $display("FAIL done_hold got st=%0d done=%0b exp 7/1", core_state, done); end
        start = 1'b0;
        tick();
        checks++; if (core_state !== 3'd0 || done !== 1'b0 || thread_enable !== 4'h0) begin errors++; $display("FAIL done_release got st=%0d done=%0b en=%b exp 0/0/0000", core_state, done, thread_enable); end
    endtask

    task automatic test_multi();
        logic [7:0] pcs [8];
        int n;
        n = 0;
        thread_count = 3'd3; block_id = 8'h11; fetch_valid = 1'b1; decoded_ret = 1'b0;
        lsu_pending = 4'h0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (done === 1'b1) break;
            next_pc = current_pc + 8'd1;
            if (core_state === 3'd1 && n < 8) begin pcs[n] = current_pc; n++; end
            decoded_ret = (n >= 3);
            tick();
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL multi_instr_count got %0d exp 3", n); end
        checks++; if (pcs[0] !== 8'd0 || pcs[1] !== 8'd1 || pcs[2] !== 8'd2) begin errors++; $display("FAIL multi_pc_seq got %0d,%0d,%0d exp 0,1,2", pcs[0], pcs[1], pcs[2]); end
        checks++; if (thread_enable !== 4'b0111 || done !== 1'b1 || current_pc !== 8'd2) begin errors++; $display("FAIL multi_end got en=%b done=%0b pc=%0d exp 0111/1/2", thread_enable, done, current_pc); end
        decoded_ret = 1'b0;
        tick();
    endtask

    task automatic run_wait(input logic [2:0] tc, output int wc);
        wc = 0;
        thread_count = tc; fetch_valid = 1'b1; decoded_ret = 1'b1; lsu_pending = 4'b1000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (done === 1'b1) break;
            if (core_state === 3'd4) begin
                wc++;
                if (wc >= 6) lsu_pending = 4'h0;
            end
            tick();
        end
        lsu_pending = 4'h0;
        tick();
    endtask

    task automatic test_wait();
        int wc;
        run_wait(3'd3, wc);
        checks++; if (wc !== 1) begin errors++; $display("FAIL wait_masked got %0d exp 1", wc); end
        run_wait(3'd4, wc);
        checks++; if (wc !== 6) begin errors++; $display("FAIL wait_stall got %0d exp 6", wc); end
    endtask

    task automatic test_thread_bounds();
        thread_count = 3'd0; start = 1'b1;
        tick();
        checks++; if (core_state !== 3'd7 || done !== 1'b1 || fetch_req !== 1'b0 || thread_enable !== 4'h0) begin errors++; $display("FAIL zero_threads got st=%0d done=%0b fr=%0b en=%b exp 7/1/0/0000", core_state, done, fetch_req, thread_enable); end
        start = 1'b0;
        tick();
        thread_count = 3'd7; fetch_valid = 1'b1; decoded_ret = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (thread_enable !== 4'b1111 || core_state !== 3'd1) begin errors++; $display("FAIL clamp_threads got en=%b st=%0d exp 1111/1", thread_enable, core_state); end
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) break;
            tick();
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int e;
        thread_count = 3'd4; block_id = 8'h3C; fetch_valid = 1'b1; decoded_ret = 1'b1;
        lsu_pending = 4'b1111; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (core_state === 3'd4) break;
            tick();
        end
        checks++; if (core_state !== 3'd4) begin errors++; $display("FAIL reach_wait got %0d exp 4", core_state); end
        #2 reset = 1'b1;
        #1;
        checks++; if (core_state !== 3'd0 || done !== 1'b0 || thread_enable !== 4'h0) begin errors++; $display("FAIL async_reset got st=%0d done=%0b en=%b exp 0/0/0000", core_state, done, thread_enable); end
        checks++; if (cur_block_id !== 8'h00 || fetch_req !== 1'b0) begin errors++; $display("FAIL async_reset_blk got blk=%0h fr=%0b exp 0/0", cur_block_id, fetch_req); end
        tick();
        reset = 1'b0; lsu_pending = 4'h0;
        tick();
        checks++; if (core_state !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL post_reset_idle got st=%0d done=%0b exp 0/0", core_state, done); end
        thread_count = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        e = 0;
        while (done !== 1'b1 && e < 30) begin tick(); e++; end
        checks++; if (e !== 6 || thread_enable !== 4'b0011) begin errors++; $display("FAIL relaunch got lat=%0d en=%b exp 6/0011", e, thread_enable); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_wait();
        test_thread_bounds();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
